z3_master_arbiter: RTL and testbench

Z3_MASTER_ARBITER -- requirements
Module: z3_master_arbiter

---
 rtl/z3_master_arbiter_pkg.sv | 33 +++
 rtl/z3_master_arbiter_sync2.sv | 27 ++
 rtl/z3_master_arbiter.sv | 130 +++++++++++++
 tb/tb_z3_master_arbiter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/z3_master_arbiter_pkg.sv
// globalparams -- shared definitions for the Zorro III card logic.
//   Z3_*  : card slave FSM states (the master arbiter watches slave_busy)
//   ARB_* : master bus arbiter FSM states
//   Default timeout / holdoff constants and a counter-width helper.
package globalparams;

  typedef enum logic [2:0] {
    Z3_IDLE  = 3'd0,
    Z3_ADDR  = 3'd1,
    Z3_DATA  = 3'd2,
    Z3_ACK   = 3'd3
  } z3_state_t;

  typedef enum logic [2:0] {
    ARB_IDLE      = 3'd0,
    ARB_REQ       = 3'd1,
    ARB_WAIT_FREE = 3'd2,
    ARB_OWN       = 3'd3,
    ARB_RELEASE   = 3'd4,
    ARB_HOLDOFF   = 3'd5
  } arb_state_t;

  localparam int unsigned ARB_TIMEOUT_DEFAULT = 1024;
  localparam int unsigned ARB_HOLDOFF_DEFAULT = 16;

  // Bits needed for a down-counter loaded with (n-1) for the larger of a, b.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/z3_master_arbiter_sync2.sv
// sync2 -- two-flop synchronizer for one asynchronous input.
//   CLK      : sampling clock
//   IORST_n  : async active-low reset, both flops forced to RESET_VAL
//   d        : asynchronous input
//   q        : synchronized output (stage 2)
module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic CLK,
  input  logic IORST_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge CLK or negedge IORST_n) begin
    if (!IORST_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/z3_master_arbiter.sv
// z3_master_arbiter -- obtains Zorro III bus mastership for the NCR DMA engine.
//   CLK, IORST_n : clock, async active-low reset
//   SBR          : NCR bus request (async)          SBG        : grant to NCR
//   BG_n         : Z3 bus grant (async, low)        BR_n       : Z3 bus request (low)
//   FCS_n        : Z3 full cycle strobe (async)     MASTER_OWN : card drives the bus
//   DTACK_n      : Z3 data ack (async)              timeout_err: 1-cycle abort pulse
//   slave_busy   : card slave FSM not in Z3_IDLE (synchronous)
// Optional feature macro: BUS_TIMEOUT_EN (request timeout + holdoff).
//
// state         | meaning
// ARB_IDLE      | no request pending, bus not owned
// ARB_REQ       | BR_n asserted, waiting for BG_n
// ARB_WAIT_FREE | granted, waiting for FCS_n and DTACK_n both high
// ARB_OWN       | card owns bus, SBG to NCR asserted
// ARB_RELEASE   | single cycle of bus release before returning idle
// ARB_HOLDOFF   | forced idle after a timeout abort (BUS_TIMEOUT_EN only)
module z3_master_arbiter
  import globalparams::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT,
  parameter int unsigned HOLDOFF_CYCLES = ARB_HOLDOFF_DEFAULT
) (
  input  logic CLK,
  input  logic IORST_n,
  input  logic SBR,
  output logic SBG,
  input  logic BG_n,
  output logic BR_n,
  input  logic FCS_n,
  input  logic DTACK_n,
  input  logic slave_busy,
  output logic MASTER_OWN,
  output logic timeout_err
);

  logic sbr_s, bg_s, fcs_s, dtack_s;

  sync2 #(.RESET_VAL(1'b0)) u_sync_sbr   (.CLK(CLK), .IORST_n(IORST_n), .d(SBR),     .q(sbr_s));
  sync2 #(.RESET_VAL(1'b1)) u_sync_bg    (.CLK(CLK), .IORST_n(IORST_n), .d(BG_n),    .q(bg_s));
  sync2 #(.RESET_VAL(1'b1)) u_sync_fcs   (.CLK(CLK), .IORST_n(IORST_n), .d(FCS_n),   .q(fcs_s));
  sync2 #(.RESET_VAL(1'b1)) u_sync_dtack (.CLK(CLK), .IORST_n(IORST_n), .d(DTACK_n), .q(dtack_s));

  arb_state_t state, next_state;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES, HOLDOFF_CYCLES);

  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;

  assign cnt_zero = (cnt == '0);

  // One down-counter serves both phases: idle keeps it preloaded with the
  // request budget, the abort reloads it with the holdoff length.
  always_ff @(posedge CLK or negedge IORST_n) begin
    if (!IORST_n) begin
      cnt <= '0;
    end else begin
      case (state)
        ARB_IDLE:                cnt <= CNT_W'(TIMEOUT_CYCLES - 1);
        ARB_REQ, ARB_WAIT_FREE:  cnt <= cnt_zero ? CNT_W'(HOLDOFF_CYCLES - 1) : cnt - 1'b1;
        ARB_HOLDOFF:             cnt <= cnt_zero ? cnt : cnt - 1'b1;
        default:                 cnt <= '0;
      endcase
    end
  end
`endif

  always_comb begin
    next_state = state;
    case (state)
      ARB_IDLE:
        if (sbr_s && !slave_busy) next_state = ARB_REQ;
      ARB_REQ:
        if (!sbr_s)               next_state = ARB_IDLE;
`ifdef BUS_TIMEOUT_EN
        else if (cnt_zero)        next_state = ARB_HOLDOFF;
`endif
        else if (!bg_s)           next_state = ARB_WAIT_FREE;
      ARB_WAIT_FREE:
        if (!sbr_s)               next_state = ARB_IDLE;
`ifdef BUS_TIMEOUT_EN
        else if (cnt_zero)        next_state = ARB_HOLDOFF;
`endif
        else if (fcs_s && dtack_s) next_state = ARB_OWN;
      ARB_OWN:
        if (!sbr_s)               next_state = ARB_RELEASE;
      ARB_RELEASE:                next_state = ARB_IDLE;
`ifdef BUS_TIMEOUT_EN
      ARB_HOLDOFF:
        if (cnt_zero)             next_state = ARB_IDLE;
`endif
      default:                    next_state = ARB_IDLE;
    endcase
  end

  // Outputs are flops fed from next_state so they change with the state
  // register and never glitch; reset clears them in the same async event.
  logic br_n_q, own_q;

  always_ff @(posedge CLK or negedge IORST_n) begin
    if (!IORST_n) begin
      state  <= ARB_IDLE;
      br_n_q <= 1'b1;
      own_q  <= 1'b0;
    end else begin
      state  <= next_state;
      br_n_q <= !((next_state == ARB_REQ) || (next_state == ARB_WAIT_FREE));
      own_q  <= (next_state == ARB_OWN);
    end
  end

  assign BR_n       = br_n_q;
  assign MASTER_OWN = own_q;
  assign SBG        = own_q;

`ifdef BUS_TIMEOUT_EN
  logic terr_q;

  always_ff @(posedge CLK or negedge IORST_n) begin
    if (!IORST_n) terr_q <= 1'b0;
    else          terr_q <= (next_state == ARB_HOLDOFF) && (state != ARB_HOLDOFF);
  end

  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_z3_master_arbiter.sv
module tb_z3_master_arbiter;
  import globalparams::*;

  logic CLK = 1'b0;
  logic IORST_n = 1'b0;
  logic SBR = 1'b0, BG_n = 1'b1, FCS_n = 1'b1, DTACK_n = 1'b1, slave_busy = 1'b0;
  logic SBG, BR_n, MASTER_OWN, timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  z3_master_arbiter #(.TIMEOUT_CYCLES(64), .HOLDOFF_CYCLES(16)) dut (
    .CLK(CLK), .IORST_n(IORST_n), .SBR(SBR), .SBG(SBG), .BG_n(BG_n), .BR_n(BR_n),
    .FCS_n(FCS_n), .DTACK_n(DTACK_n), .slave_busy(slave_busy),
    .MASTER_OWN(MASTER_OWN), .timeout_err(timeout_err)
  );

  typedef struct {
    logic sbr, bg_n, fcs_n, dtack_n, busy;
    logic br_n, own, terr;
  } vec_t;

  typedef struct {
    logic br_n, own, terr;
    string tag;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[18];

  task automatic chk(input string tag, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", tag, act, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs, advance one clock,
  // then pop and compare against what the DUT shows.
  task automatic step(input logic sbr, input logic bg, input logic fcs, input logic dt,
                      input logic busy, input logic ebr, input logic eown,
                      input logic eterr, input string tag);
    exp_t e;
    SBR = sbr; BG_n = bg; FCS_n = fcs; DTACK_n = dt; slave_busy = busy;
    e.br_n = ebr; e.own = eown; e.terr = eterr; e.tag = tag;
    sb_q.push_back(e);
    @(posedge CLK); #1;
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, ".BR_n"}, BR_n, e.br_n);
      chk({e.tag, ".MASTER_OWN"}, MASTER_OWN, e.own);
      chk({e.tag, ".SBG"}, SBG, e.own);
      chk({e.tag, ".timeout_err"}, timeout_err, e.terr);
    end
  endtask

  task automatic idle_steps(input int n, input string tag);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, $sformatf("%s[%0d]", tag, i));
  endtask

  initial begin
    // sbr, bg_n, fcs_n, dtack_n, busy | br_n, own, terr
    tbl[0]  = '{1, 1, 1, 1, 0, 1, 0, 0};
    tbl[1]  = '{1, 1, 1, 1, 0, 1, 0, 0};
    tbl[2]  = '{1, 1, 1, 1, 0, 0, 0, 0};  // BR_n low 3 clocks after SBR
    tbl[3]  = '{1, 1, 1, 1, 0, 0, 0, 0};
    tbl[4]  = '{1, 1, 1, 1, 0, 0, 0, 0};
    tbl[5]  = '{1, 0, 1, 1, 0, 0, 0, 0};  // grant arrives
    tbl[6]  = '{1, 0, 1, 1, 0, 0, 0, 0};
    tbl[7]  = '{1, 0, 1, 1, 0, 0, 0, 0};  // WAIT_FREE
    tbl[8]  = '{1, 0, 1, 1, 0, 1, 1, 0};  // OWN one clock after idle sample
    tbl[9]  = '{1, 0, 1, 1, 0, 1, 1, 0};
    tbl[10] = '{0, 0, 1, 1, 0, 1, 1, 0};  // one-cycle SBR drop
    tbl[11] = '{1, 1, 1, 1, 0, 1, 1, 0};
    tbl[12] = '{1, 1, 1, 1, 0, 1, 0, 0};  // RELEASE
    tbl[13] = '{1, 1, 1, 1, 0, 1, 0, 0};  // mandatory IDLE
    tbl[14] = '{1, 1, 1, 1, 0, 0, 0, 0};  // re-request
    tbl[15] = '{0, 1, 1, 1, 0, 0, 0, 0};
    tbl[16] = '{0, 1, 1, 1, 0, 0, 0, 0};
    tbl[17] = '{0, 1, 1, 1, 0, 1, 0, 0};  // request withdrawn

    // reset state
    #12;
    chk("reset.BR_n", BR_n, 1'b1);
    chk("reset.SBG", SBG, 1'b0);
    chk("reset.MASTER_OWN", MASTER_OWN, 1'b0);
    chk("reset.timeout_err", timeout_err, 1'b0);
    checks++;
    if (dut.state !== ARB_IDLE) begin
      errors++;
      $display("FAIL reset.state actual=%0d expected=%0d", dut.state, ARB_IDLE);
    end
    @(posedge CLK); #1;
    IORST_n = 1'b1;
    idle_steps(2, "post_reset");

    // basic tenure, release, and minimum idle gap
    for (int i = 0; i < 18; i++)
      step(tbl[i].sbr, tbl[i].bg_n, tbl[i].fcs_n, tbl[i].dtack_n, tbl[i].busy,
           tbl[i].br_n, tbl[i].own, tbl[i].terr, $sformatf("tbl[%0d]", i));

    // slave activity defers the request
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, $sformatf("busy[%0d]", i));
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "busy_drop");
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "busy_w0");
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "busy_w1");
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "busy_w2");

    // granted while bus busy: FCS_n low steps 0-7, DTACK_n low steps 6-9
    for (int i = 0; i < 17; i++) begin
      logic sbr, fcs, dt, ebr, eown;
      sbr  = (i < 13);
      fcs  = (i >= 8);
      dt   = !(i >= 6 && i <= 9);
      eown = (i >= 12 && i <= 14);
      ebr  = !(i >= 2 && i <= 11);
      step(sbr, 1'b0, fcs, dt, 1'b0, ebr, eown, 1'b0, $sformatf("busfree[%0d]", i));
    end
    idle_steps(3, "gap1");

`ifdef BUS_TIMEOUT_EN
    // never granted: abort after 64 request cycles, then 16 holdoff cycles
    for (int i = 0; i < 84; i++) begin
      logic ebr, eterr;
      ebr   = !((i >= 2 && i <= 65) || i >= 83);
      eterr = (i == 66);
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, ebr, 1'b0, eterr, $sformatf("timeout[%0d]", i));
    end
`else
    // never granted: request waits indefinitely
    for (int i = 0; i < 100; i++)
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, !(i >= 2), 1'b0, 1'b0, $sformatf("nowait[%0d]", i));
`endif
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "withdraw0");
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "withdraw1");
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "withdraw2");
    idle_steps(2, "gap2");

    // reset in the middle of a tenure
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "rst_own[0]");
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "rst_own[1]");
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "rst_own[2]");
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "rst_own[3]");
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "rst_own[4]");
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "rst_own[5]");
    #2;
    IORST_n = 1'b0;
    SBR = 1'b0; BG_n = 1'b1;
    #1;
    chk("midrst.BR_n", BR_n, 1'b1);
    chk("midrst.SBG", SBG, 1'b0);
    chk("midrst.MASTER_OWN", MASTER_OWN, 1'b0);
    checks++;
    if (dut.state !== ARB_IDLE) begin
      errors++;
      $display("FAIL midrst.state actual=%0d expected=%0d", dut.state, ARB_IDLE);
    end
    #2;
    IORST_n = 1'b1;
    @(posedge CLK); #1;
    idle_steps(2, "after_rst");
    checks++;
    if (dut.state !== ARB_IDLE) begin
      errors++;
      $display("FAIL after_rst.state actual=%0d expected=%0d", dut.state, ARB_IDLE);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
